// File: rtl/e203_exu_fpu_fmis_mvx_if.sv
// Issue and writeback handshake bundle for the FP-to-integer move/classify unit.
//   slave  : unit view (consumes issue, produces writeback)
//   master : environment view (dispatch plus writeback arbiter)
// Issue side : fmis_mvx_i_valid/ready, fmis_i_rs1, fmis_i_op, fmis_i_rdidx, fmis_i_flush
// Wback side : fmis_mvx_o_valid/ready, fmis_mvx_o_wbck_wdat, fmis_mvx_o_wbck_rdidx
// Status     : fmis_mvx_busy
interface e203_exu_fpu_fmis_mvx_if #(
  parameter int unsigned RDIDX_W = 5
);
  logic               fmis_mvx_i_valid;
  logic               fmis_mvx_i_ready;
  logic [31:0]        fmis_i_rs1;
  logic               fmis_i_op;
  logic [RDIDX_W-1:0] fmis_i_rdidx;
  logic               fmis_i_flush;
  logic               fmis_mvx_o_valid;
  logic               fmis_mvx_o_ready;
  logic [31:0]        fmis_mvx_o_wbck_wdat;
  logic [RDIDX_W-1:0] fmis_mvx_o_wbck_rdidx;
  logic               fmis_mvx_busy;

  modport slave (
    input  fmis_mvx_i_valid, fmis_i_rs1, fmis_i_op, fmis_i_rdidx, fmis_i_flush,
    input  fmis_mvx_o_ready,
    output fmis_mvx_i_ready, fmis_mvx_o_valid, fmis_mvx_o_wbck_wdat,
    output fmis_mvx_o_wbck_rdidx, fmis_mvx_busy
  );

  modport master (
    output fmis_mvx_i_valid, fmis_i_rs1, fmis_i_op, fmis_i_rdidx, fmis_i_flush,
    output fmis_mvx_o_ready,
    input  fmis_mvx_i_ready, fmis_mvx_o_valid, fmis_mvx_o_wbck_wdat,
    input  fmis_mvx_o_wbck_rdidx, fmis_mvx_busy
  );
endinterface

// File: rtl/e203_exu_fpu_fmis_mvx.sv
// FP-to-integer move/classify unit (FMV.X.W and FCLASS.S) with a 2-entry
// registered skid buffer in front of the integer writeback arbiter.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : issue/writeback handshake bundle (slave view)
// Issue ready depends only on registered occupancy, flush and reset, so there
// is no combinational path from writeback ready back to dispatch.
module e203_exu_fpu_fmis_mvx #(
  parameter int unsigned RDIDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  e203_exu_fpu_fmis_mvx_if.slave  bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CLASS_W = 10;

  typedef struct packed {
    logic [DATA_W-1:0]  wdat;
    logic [RDIDX_W-1:0] rdidx;
  } res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;
  res_t   main_q, skid_q, res_c;
  logic   accept, drain;
  logic   load_main_new, load_main_skid, load_skid;

  // FCLASS.S field decode
  logic               sgn, exp_ones, exp_zero, frac_zero, quiet;
  logic [CLASS_W-1:0] cls;

  always_comb begin
    sgn       = bus.fmis_i_rs1[31];
    exp_ones  = &bus.fmis_i_rs1[30:23];
    exp_zero  = ~|bus.fmis_i_rs1[30:23];
    frac_zero = ~|bus.fmis_i_rs1[22:0];
    quiet     = bus.fmis_i_rs1[22];
    cls       = '0;
    cls[0]    =  sgn & exp_ones & frac_zero;
    cls[1]    =  sgn & ~exp_ones & ~exp_zero;
    cls[2]    =  sgn & exp_zero & ~frac_zero;
    cls[3]    =  sgn & exp_zero & frac_zero;
    cls[4]    = ~sgn & exp_zero & frac_zero;
    cls[5]    = ~sgn & exp_zero & ~frac_zero;
    cls[6]    = ~sgn & ~exp_ones & ~exp_zero;
    cls[7]    = ~sgn & exp_ones & frac_zero;
    cls[8]    =  exp_ones & ~frac_zero & ~quiet;
    cls[9]    =  exp_ones & quiet;
  end

  // Result is formed once at accept and never recomputed
  always_comb begin
    res_c.rdidx = bus.fmis_i_rdidx;
    res_c.wdat  = bus.fmis_i_op ? DATA_W'(cls) : bus.fmis_i_rs1;
  end

  // Handshakes and status
  assign bus.fmis_mvx_i_ready      = (state != TWO) & ~bus.fmis_i_flush & rst_n;
  assign accept                    = bus.fmis_mvx_i_valid & bus.fmis_mvx_i_ready;
  assign drain                     = bus.fmis_mvx_o_valid & bus.fmis_mvx_o_ready;
  assign bus.fmis_mvx_o_valid      = (state != EMPTY);
  // Skid is only ever occupied together with main, so main-valid covers both
  assign bus.fmis_mvx_busy         = (state != EMPTY);
  assign bus.fmis_mvx_o_wbck_wdat  = main_q.wdat;
  assign bus.fmis_mvx_o_wbck_rdidx = main_q.rdidx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state and buffer load controls; flush overrides accept and drain
  always_comb begin
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.fmis_i_flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt     = ONE;
            load_main_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (drain && !accept) begin
            state_nxt = EMPTY;
          end else if (accept && drain) begin
            load_main_new = 1'b1;
          end
        end
        TWO: begin
          // i_ready is low in TWO, so only a drain can happen here
          if (drain) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload registers; only the valids (state) clear on flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new)       main_q <= res_c;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= res_c;
    end
  end

endmodule
